// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, FSM state type and opcode legality check for the
// ALU sharing controller.
package alu_ctrl_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal_op = 1'b1;
         default:                               is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two issuing requesters and the shared
// ALU controller.
interface alu_share_ctrl_if #(
   parameter int W = 16
);
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [2:0]   req_op0;
   logic [W-1:0] req_a0;
   logic [W-1:0] req_b0;
   logic [2:0]   req_op1;
   logic [W-1:0] req_a1;
   logic [W-1:0] req_b1;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
   logic         rsp_zero;
   logic         rsp_err;

   modport master (
      output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
   );

   modport slave (
      input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the prio requester wins a tie, otherwise any
// single valid requester is granted.
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       prio,
   output logic [1:0] grant
);
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_grant
         assign grant[gi] = req_valid[gi] && ((prio == 1'(gi)) || !req_valid[1-gi]);
      end
   endgenerate
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// timed execution, registered result returned on a valid/ready channel.
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int W           = 16,
   parameter int EXEC_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_share_ctrl_if.slave bus,
   output logic [2:0]      alu_op,
   output logic [W-1:0]    alu_a,
   output logic [W-1:0]    alu_b,
   input  logic [W-1:0]    alu_result,
   input  logic            alu_zero,
   output logic            busy,
   output logic [15:0]     op_count
);

   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   state_t       state_reg;
   logic         prio_reg;
   logic [3:0]   cnt_reg;
   logic [2:0]   op_reg;
   logic [W-1:0] a_reg;
   logic [W-1:0] b_reg;
   logic         rsp_valid_reg;
   logic         rsp_id_reg;
   logic [W-1:0] rsp_data_reg;
   logic         rsp_zero_reg;
   logic         rsp_err_reg;
   logic         busy_reg;
   logic [15:0]  op_count_reg;

   logic [1:0]   grant;
   logic         win_id;
   logic [2:0]   win_op;
   logic [W-1:0] win_a;
   logic [W-1:0] win_b;

   rr_arb2 u_arb (
      .req_valid (bus.req_valid),
      .prio      (prio_reg),
      .grant     (grant)
   );

   assign bus.req_ready = (state_reg == ST_IDLE) ? grant : 2'b00;

   assign win_id = grant[1];
   assign win_op = win_id ? bus.req_op1 : bus.req_op0;
   assign win_a  = win_id ? bus.req_a1  : bus.req_a0;
   assign win_b  = win_id ? bus.req_b1  : bus.req_b0;

   assign alu_op = op_reg;
   assign alu_a  = a_reg;
   assign alu_b  = b_reg;

   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_zero  = rsp_zero_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign busy          = busy_reg;
   assign op_count      = op_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         prio_reg      <= 1'b0;
         cnt_reg       <= 4'd0;
         op_reg        <= 3'b000;
         a_reg         <= '0;
         b_reg         <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_zero_reg  <= 1'b0;
         rsp_err_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         op_count_reg  <= 16'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (|grant) begin
                  rsp_id_reg <= win_id;
                  busy_reg   <= 1'b1;
                  // Illegal ops bypass the ALU, so its inputs keep their last values.
                  if (is_legal_op(win_op)) begin
                     op_reg    <= win_op;
                     a_reg     <= win_a;
                     b_reg     <= win_b;
                     cnt_reg   <= CNT_LOAD;
                     state_reg <= ST_EXEC;
                  end else begin
                     rsp_data_reg  <= '0;
                     rsp_zero_reg  <= 1'b0;
                     rsp_err_reg   <= 1'b1;
                     rsp_valid_reg <= 1'b1;
                     state_reg     <= ST_RESP;
                  end
               end
            end
            ST_EXEC: begin
               if (cnt_reg == 4'd0) begin
                  rsp_data_reg  <= alu_result;
                  rsp_zero_reg  <= alu_zero;
                  rsp_err_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= ST_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  prio_reg      <= ~rsp_id_reg;
                  op_count_reg  <= op_count_reg + 16'd1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized and directed checks of alu_share_ctrl against a transaction-level
// model of arbitration, latency, results and counters.
module tb_alu_share_ctrl;

   localparam int EC = 4;

   logic        clk;
   logic        rst_n;
   logic [2:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic        alu_zero;
   logic        busy;
   logic [15:0] op_count;

   alu_share_ctrl_if #(.W(16)) bus ();

   alu_share_ctrl #(.W(16), .EXEC_CYCLES(EC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .busy       (busy),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
         default: return 16'hDEAD;
      endcase
   endfunction

   // Behavioural ALU that the controller drives.
   always_comb begin
      alu_result = ref_alu(alu_op, alu_a, alu_b);
      alu_zero   = (alu_result == 16'd0);
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [2:0]  p_op [2];
   logic [15:0] p_a  [2];
   logic [15:0] p_b  [2];
   logic [1:0]  p_v;
   logic        m_prio;
   int unsigned m_count;
   logic [2:0]  m_alu_op;
   logic [15:0] m_alu_a;
   logic [15:0] m_alu_b;

   task automatic drive_bus();
      bus.req_valid = p_v;
      bus.req_op0 = p_op[0]; bus.req_a0 = p_a[0]; bus.req_b0 = p_b[0];
      bus.req_op1 = p_op[1]; bus.req_a1 = p_a[1]; bus.req_b1 = p_b[1];
   endtask

   task automatic model_reset();
      m_prio = 1'b0; m_count = 0;
      m_alu_op = 3'b000; m_alu_a = 16'h0; m_alu_b = 16'h0;
   endtask

   // Serves the requester the model says must win, holding rsp_ready low for 'hold' cycles.
   task automatic serve_one(input string name, input int hold);
      int w, cyc, lat;
      logic legal, exp_z, exp_e;
      logic [2:0] eop;
      logic [15:0] ea, eb, exp_d;
      w = p_v[m_prio] ? int'(m_prio) : int'(!m_prio);
      eop = p_op[w]; ea = p_a[w]; eb = p_b[w];
      legal = (eop == 3'b000) || (eop == 3'b001) || (eop == 3'b010) || (eop == 3'b110) || (eop == 3'b111);
      exp_d = legal ? ref_alu(eop, ea, eb) : 16'h0;
      exp_z = legal && (exp_d == 16'h0);
      exp_e = !legal;
      drive_bus(); #1;
      cyc = 0;
      while (bus.req_ready == 2'b00 && cyc < 40) begin @(negedge clk); #1; cyc++; end
      n_checks++;
      if (bus.req_ready !== (2'b01 << w)) begin
         $display("FAIL %s grant: req_ready=%b expected %b", name, bus.req_ready, 2'b01 << w); n_fail++;
      end
      @(negedge clk);
      p_v[w] = 1'b0; drive_bus(); #1;
      n_checks++;
      if (busy !== 1'b1 || bus.req_ready !== 2'b00) begin
         $display("FAIL %s busy_after_accept: busy=%b req_ready=%b expected 1/00", name, busy, bus.req_ready); n_fail++;
      end
      if (legal) begin m_alu_op = eop; m_alu_a = ea; m_alu_b = eb; end
      n_checks++;
      if ({alu_op, alu_a, alu_b} !== {m_alu_op, m_alu_a, m_alu_b}) begin
         $display("FAIL %s alu_inputs: %h/%h/%h expected %h/%h/%h", name, alu_op, alu_a, alu_b, m_alu_op, m_alu_a, m_alu_b); n_fail++;
      end
      lat = 1;
      while (!bus.rsp_valid && lat < 40) begin @(negedge clk); #1; lat++; end
      n_checks++;
      if (lat !== (legal ? EC + 1 : 1)) begin
         $display("FAIL %s latency: %0d cycles expected %0d", name, lat, legal ? EC + 1 : 1); n_fail++;
      end
      for (int k = 0; k <= hold; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         n_checks++;
         if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero, bus.rsp_err} !== {1'b1, 1'(w), exp_d, exp_z, exp_e}) begin
            $display("FAIL %s response[%0d]: v=%b id=%b data=%h zero=%b err=%b expected 1 %0d %h %b %b",
                     name, k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero, bus.rsp_err, w, exp_d, exp_z, exp_e);
            n_fail++;
         end
         n_checks++;
         if (busy !== 1'b1 || bus.req_ready !== 2'b00) begin
            $display("FAIL %s hold_busy[%0d]: busy=%b req_ready=%b expected 1/00", name, k, busy, bus.req_ready); n_fail++;
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk); #1;
      bus.rsp_ready = 1'b0;
      m_count++;
      m_prio = !1'(w);
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'(m_count)) begin
         $display("FAIL %s after_handshake: v=%b busy=%b op_count=%0d expected 0 0 %0d", name, bus.rsp_valid, busy, op_count, m_count);
         n_fail++;
      end
      $display("txn %s: id=%0d op=%b a=%h b=%h -> data=%h zero=%b err=%b lat=%0d", name, w, eop, ea, eb, bus.rsp_data, exp_z, exp_e, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; p_v = 2'b00; bus.rsp_ready = 1'b0;
      for (int r = 0; r < 2; r++) begin p_op[r] = 3'b000; p_a[r] = 16'h0; p_b[r] = 16'h0; end
      drive_bus(); model_reset();
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({bus.rsp_valid, busy, bus.rsp_err, bus.rsp_zero, bus.rsp_id, bus.req_ready} !== 7'b0 ||
          bus.rsp_data !== 16'h0 || op_count !== 16'h0 || {alu_op, alu_a, alu_b} !== 35'h0) begin
         $display("FAIL reset_state: v=%b busy=%b data=%h op_count=%h alu=%h/%h/%h expected all 0",
                  bus.rsp_valid, busy, bus.rsp_data, op_count, alu_op, alu_a, alu_b);
         n_fail++;
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_add();
      p_op[0] = 3'b010; p_a[0] = 16'h0005; p_b[0] = 16'h0001; p_v = 2'b01;
      serve_one("single_add", 0);
      n_checks++;
      if (bus.rsp_data !== 16'h0006 && bus.rsp_valid) begin
         $display("FAIL single_add_const: data=%h expected 0006", bus.rsp_data); n_fail++;
      end
   endtask

   task automatic test_tie();
      model_reset();
      rst_n = 1'b0; #1; rst_n = 1'b1;
      p_op[0] = 3'b000; p_a[0] = 16'h0007; p_b[0] = 16'h0001;
      p_op[1] = 3'b110; p_a[1] = 16'h000F; p_b[1] = 16'h0001;
      p_v = 2'b11;
      serve_one("tie_first", 0);
      serve_one("tie_second", 0);
   endtask

   task automatic test_slt_zero();
      p_op[1] = 3'b111; p_a[1] = 16'h0005; p_b[1] = 16'h0001; p_v = 2'b10;
      serve_one("slt_false", 0);
      p_op[1] = 3'b111; p_a[1] = 16'h000E; p_b[1] = 16'h000F; p_v = 2'b10;
      serve_one("slt_true", 0);
   endtask

   task automatic test_illegal();
      p_op[0] = 3'b100; p_a[0] = 16'h1234; p_b[0] = 16'h5678; p_v = 2'b01;
      serve_one("illegal_100", 0);
      p_op[1] = 3'b011; p_a[1] = 16'hFFFF; p_b[1] = 16'h0001; p_v = 2'b10;
      serve_one("illegal_011", 1);
   endtask

   task automatic test_backpressure();
      p_op[0] = 3'b001; p_a[0] = 16'h00F0; p_b[0] = 16'h000F;
      p_op[1] = 3'b010; p_a[1] = 16'hFFFF; p_b[1] = 16'h0001;
      p_v = 2'b11;
      serve_one("backpressure", 5);
      serve_one("after_backpressure", 0);
   endtask

   task automatic test_reset_mid_exec();
      int cyc;
      p_op[0] = 3'b010; p_a[0] = 16'h0AAA; p_b[0] = 16'h0555; p_v = 2'b01;
      drive_bus(); #1;
      cyc = 0;
      while (!bus.req_ready[0] && cyc < 40) begin @(negedge clk); #1; cyc++; end
      @(negedge clk);
      p_v = 2'b00; drive_bus();
      @(negedge clk); #1;
      n_checks++;
      if (busy !== 1'b1 || alu_a !== 16'h0AAA) begin
         $display("FAIL mid_exec_busy: busy=%b alu_a=%h expected 1/0aaa", busy, alu_a); n_fail++;
      end
      rst_n = 1'b0; #1;
      n_checks++;
      if ({bus.rsp_valid, busy, bus.rsp_err, bus.rsp_zero, bus.rsp_id} !== 5'b0 || bus.rsp_data !== 16'h0 ||
          op_count !== 16'h0 || {alu_op, alu_a, alu_b} !== 35'h0) begin
         $display("FAIL mid_exec_reset: v=%b busy=%b data=%h op_count=%h alu=%h/%h/%h expected all 0",
                  bus.rsp_valid, busy, bus.rsp_data, op_count, alu_op, alu_a, alu_b);
         n_fail++;
      end
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      p_op[1] = 3'b110; p_a[1] = 16'h0003; p_b[1] = 16'h0003; p_v = 2'b10;
      serve_one("after_reset", 0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         for (int r = 0; r < 2; r++) begin
            p_op[r] = 3'($urandom_range(0, 7));
            p_a[r]  = 16'($urandom);
            p_b[r]  = ($urandom_range(0, 3) == 0) ? p_a[r] : 16'($urandom);
         end
         p_v = 2'($urandom_range(1, 3));
         while (p_v != 2'b00) serve_one("random", int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_tie();
      test_slt_zero();
      test_illegal();
      test_backpressure();
      test_reset_mid_exec();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
